// File: rtl/filter_chain_pkg.sv
// Shared types and constants for the filter chain sequencer.
// The top module and its wait timer both import this package.
package filter_chain_pkg;

  localparam int DATA_W_DEF     = 24;
  localparam int NUM_STAGES_MAX = 8;
  localparam int NUM_CH_MAX     = 8;
  localparam int DROP_CNT_W     = 8;

  typedef enum logic [2:0] {
    FCS_IDLE   = 3'd0,
    FCS_SELECT = 3'd1,
    FCS_ISSUE  = 3'd2,
    FCS_WAIT   = 3'd3,
    FCS_NEXT   = 3'd4,
    FCS_DONE   = 3'd5
  } fcs_state_t;

  typedef logic [DATA_W_DEF-1:0] sample_t;

  // Index width for a counter over n items. A single item still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when the stage and channel counts are within the supported range.
  function automatic bit cfg_in_range(input int ns, input int nc);
    return (ns >= 1) && (ns <= NUM_STAGES_MAX) && (nc >= 1) && (nc <= NUM_CH_MAX);
  endfunction

endpackage

// File: rtl/fcs_timeout_cnt.sv
// Wait timer for one stage handshake.
// 'clear' restarts the count. While 'enable' is high, 'expired' pulses
// in the TIMEOUT-th enabled cycle. The counter then stops there.
module fcs_timeout_cnt
  import filter_chain_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  assign expired = enable && (cnt == LAST);

  // Count cycles spent waiting; clear restarts, the count stops at expiry
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/filter_chain_sequencer.sv
// Filter chain sequencer. Each captured frame goes through the external
// filter stages in order, one channel at a time, using a trig/end handshake.
// Optional build macro FCS_ERR_MUTE_EN: when a stage times out, the
// channel's sample is forced to zero and its remaining stages are skipped.
module filter_chain_sequencer
  import filter_chain_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_STAGES = 3,
  parameter int NUM_CH     = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_trig,
  input  logic [NUM_CH*DATA_W-1:0]     ch_in,
  input  logic [NUM_STAGES-1:0]        bypass,
  output logic [NUM_CH*DATA_W-1:0]     ch_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic [DATA_W-1:0]            stg_data,
  output logic [NUM_STAGES-1:0]        stg_trig,
  input  logic [NUM_STAGES*DATA_W-1:0] stg_result,
  input  logic [NUM_STAGES-1:0]        stg_end,
  output logic                         err_timeout,
  output logic [DROP_CNT_W-1:0]        drop_cnt
);

  localparam logic [2:0] IDLE   = FCS_IDLE;
  localparam logic [2:0] SELECT = FCS_SELECT;
  localparam logic [2:0] ISSUE  = FCS_ISSUE;
  localparam logic [2:0] WAIT   = FCS_WAIT;
  localparam logic [2:0] NEXT   = FCS_NEXT;
  localparam logic [2:0] DONE   = FCS_DONE;

  localparam int SW = idx_w(NUM_STAGES);
  localparam int CW = idx_w(NUM_CH);
  localparam logic [SW-1:0] S_LAST = SW'(NUM_STAGES - 1);
  localparam logic [CW-1:0] C_LAST = CW'(NUM_CH - 1);

  logic [2:0]            state;
  logic [SW-1:0]         s;
  logic [CW-1:0]         ch;
  logic [NUM_STAGES-1:0] byp;
  logic [DATA_W-1:0]     work [NUM_CH];
  logic                  wait_clear;
  logic                  wait_en;
  logic                  expired;

  assign wait_clear = (state == ISSUE);
  assign wait_en    = (state == WAIT);

  fcs_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (wait_clear),
    .enable (wait_en),
    .expired(expired)
  );

  // Frame sequencing: capture, per-channel/per-stage handshake, publish result
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      s           <= '0;
      ch          <= '0;
      byp         <= '0;
      ch_out      <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      stg_trig    <= '0;
      stg_data    <= '0;
      err_timeout <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) work[c] <= '0;
    end else begin
      out_valid <= 1'b0;
      stg_trig  <= '0;
      if (out_valid) busy <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_trig && !busy) begin
            for (int c = 0; c < NUM_CH; c++) work[c] <= ch_in[c*DATA_W +: DATA_W];
            byp   <= bypass;
            s     <= '0;
            ch    <= '0;
            busy  <= 1'b1;
            state <= SELECT;
          end
        end
        SELECT: begin
          if (byp[s]) begin
            state <= NEXT;
          end else begin
            stg_data <= work[ch];
            stg_trig <= NUM_STAGES'(1) << s;
            state    <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (stg_end[s]) begin
            work[ch] <= stg_result[s*DATA_W +: DATA_W];
            state    <= NEXT;
          end else if (expired) begin
            err_timeout <= 1'b1;
`ifdef FCS_ERR_MUTE_EN
            work[ch] <= '0;
            s        <= S_LAST;
`endif
            state <= NEXT;
          end
        end
        NEXT: begin
          if (s != S_LAST) begin
            s     <= s + 1'b1;
            state <= SELECT;
          end else if (ch != C_LAST) begin
            ch    <= ch + 1'b1;
            s     <= '0;
            state <= SELECT;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          for (int c = 0; c < NUM_CH; c++) ch_out[c*DATA_W +: DATA_W] <= work[c];
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Count frame requests that arrive while a frame is still in flight; saturates
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (sample_trig && busy && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: doc/filter_chain_sequencer.md
Name: filter_chain_sequencer

Overview:
- Parametrised controller that pushes each audio sample frame, one channel at a time, through NUM_STAGES external filter engines in order.
- Each stage uses a trig/end handshake; any stage can be bypassed at runtime.
- Sits between the codec wrapper (ready/bus_out) and the codec bus_in; replaces hand-wired per-filter chaining.
- Adds multi-channel support, per-stage timeout protection and dropped-frame accounting.

Parameters:
- DATA_W, 24, sample width in bits (two's complement).
- NUM_STAGES, 3, number of chained filter engines (1..8).
- NUM_CH, 2, channels per frame (1..8); channel 0 is processed first.
- TIMEOUT, 1023, maximum cycles waited for stg_end after stg_trig (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sample_trig  in  1  one-cycle pulse: new frame available on ch_in.
- ch_in  in  NUM_CH*DATA_W  input frame; channel c occupies bits [c*DATA_W +: DATA_W].
- bypass  in  NUM_STAGES  bit s=1 skips stage s; sampled at frame capture.
- ch_out  out  NUM_CH*DATA_W  last completed output frame.
- out_valid  out  1  one-cycle pulse when ch_out updates.
- busy  out  1  high from capture until the out_valid cycle inclusive.
- stg_data  out  DATA_W  sample presented to the active stage; held until stg_end or timeout.
- stg_trig  out  NUM_STAGES  one-hot, one-cycle start pulse to stage s.
- stg_result  in  NUM_STAGES*DATA_W  result of stage s, valid in the stg_end cycle.
- stg_end  in  NUM_STAGES  stage s completion pulse.
- err_timeout  out  1  sticky; set on any stage timeout; cleared only by reset.
- drop_cnt  out  8  saturating count of sample_trig pulses ignored while busy.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; ch_out=0; out_valid=0; busy=0; stg_trig=0; stg_data=0; err_timeout=0; drop_cnt=0; internal frame and bypass latches=0.
  - Reset mid-operation aborts the frame at the next edge: no out_valid, stg_trig deasserted.
  - Late stg_end pulses arriving after reset are ignored.
- States: IDLE, SELECT, ISSUE, WAIT, NEXT, DONE.
- IDLE: when sample_trig=1, latch ch_in and bypass, set ch=0, s=0, busy=1, go to SELECT.
- SELECT:
  - bypass[s]=1: go to NEXT. The sample is unchanged and the skip costs 1 cycle.
  - Otherwise drive stg_data=work[ch] and go to ISSUE.
- ISSUE: stg_trig[s]=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - On stg_end[s]=1: work[ch] <= stg_result[s]; go to NEXT.
  - stg_end bits for s' != s are ignored.
  - If the counter reaches TIMEOUT with no end: set err_timeout, leave work[ch] unchanged (see the optional feature), go to NEXT.
  - stg_end in the same cycle the counter reaches TIMEOUT counts as success.
- NEXT:
  - If s<NUM_STAGES-1: s++, go to SELECT.
  - Else if ch<NUM_CH-1: ch++, s=0, go to SELECT.
  - Else go to DONE.
- DONE: ch_out <= work; out_valid=1 for one cycle; busy drops on the next edge; return to IDLE.
- Latency:
  - All stages bypassed: out_valid occurs 2+2*NUM_STAGES*NUM_CH cycles after the sample_trig edge.
  - Each active stage adds 2 cycles plus its response time.
- Drops: sample_trig while busy=1 (including the DONE cycle) is ignored; drop_cnt increments and saturates at 255.
- Arithmetic: no arithmetic on samples; data is routed only. Counters are sized with $clog2 and ch/s wrap only through the NEXT rules above.
- ch_out holds its value between frames.

Optional Feature:
- Macro: FCS_ERR_MUTE_EN.
- Defined: a timeout in any stage forces that channel's work sample to 0 and skips its remaining stages for this frame. Other channels are processed normally.
- Undefined: a timeout leaves the sample unchanged (pass-through) and later stages still run.
- err_timeout behaves identically in both builds.

Decomposition:
- Package filter_chain_pkg:
  - state enum fcs_state_t;
  - localparams DATA_W_DEF=24, NUM_STAGES_MAX=8, NUM_CH_MAX=8, DROP_CNT_W=8;
  - a sample_t typedef.
- One sub-module, fcs_timeout_cnt: counter with clear and enable, TIMEOUT parameter, and a single-cycle expired output. It is reused for the per-stage wait.

Test Plan:
- All bypassed, NUM_CH=2, ch_in={24'h123456, 24'hABCDEF}, sample_trig -> out_valid 14 cycles later, ch_out equals ch_in, stg_trig never asserted.
- bypass=3'b000, stage model returns data+1 after 5 cycles, ch0=24'h000010 -> ch_out ch0=24'h000013; stg_trig pulses ordered 0,1,2,0,1,2.
- TIMEOUT=15, stage 1 silent, input 24'h000100, stages add 1 -> err_timeout=1 and ch_out=24'h000102 (macro off) or 24'h000000 (FCS_ERR_MUTE_EN on).
- 300 sample_trig pulses while busy -> drop_cnt=255 and holds; pulse in the DONE cycle counted as a drop.
- Reset asserted in WAIT of stage 1 -> next cycle stg_trig=0, busy=0, ch_out=0, no out_valid; a late stg_end is ignored.
- bypass changed mid-frame from 3'b000 to 3'b111 -> the current frame still uses all stages; the next frame uses none.
